uart_axil_regs: RTL and testbench



---
 rtl/uart_axil_pkg.sv | 35 +++
 rtl/uart_axil_regs_sync_fifo.sv | 59 +++++
 rtl/uart_axil_regs.sv | 199 +++++++++++++++++++
 tb/tb_uart_axil_regs.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_pkg.sv
// Shared definitions for the AXI4-Lite UART register block: register map,
// status/control bit positions, response codes and FSM state types.
package uart_axil_pkg;

    localparam logic [1:0] REG_RX_FIFO = 2'd0;
    localparam logic [1:0] REG_TX_FIFO = 2'd1;
    localparam logic [1:0] REG_STAT    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_RX_NOT_EMPTY = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_INTR_EN      = 4;
    localparam int STAT_OVERRUN      = 5;
    localparam int STAT_FRAME_ERR    = 6;
    localparam int STAT_WIDTH        = 7;

    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_INTR_EN  = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_e;

endpackage

// File: rtl/uart_axil_regs_sync_fifo.sv
// Byte-wide first-word-fall-through FIFO with synchronous flush; a push into a
// full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Flush beats any push or pop issued in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front end for a UART: TX/RX byte FIFOs, sticky error
// status, FIFO flush control and an edge-triggered interrupt pulse.
module uart_axil_regs
    import uart_axil_pkg::*;
#(
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        rx_frame_err,
    output logic                        interrupt
);

    wr_state_e                   wr_state_q, wr_state_d;
    rd_state_e                   rd_state_q, rd_state_d;
    logic [S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                        ready_q;
    logic                        intr_en_q, intr_en_d;
    logic                        overrun_q, overrun_d;
    logic                        frame_err_q, frame_err_d;
    logic                        rx_was_empty_q, tx_was_empty_q, intr_en_prev_q;
    logic                        interrupt_q, interrupt_d;

    logic [1:0]            wr_sel, rd_sel;
    logic                  aw_hs, ar_hs;
    logic                  tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic                  rx_pop, rx_flush, rx_empty, rx_full;
    logic [7:0]            tx_head, rx_head;
    logic [STAT_WIDTH-1:0] stat;
    logic                  ctrl_wr, stat_rd;
    logic                  unused_ok;

    assign unused_ok = ^{s_axi_awaddr[S_AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                         s_axi_araddr[S_AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                         s_axi_wdata[S_AXI_DATA_WIDTH-1:8]};

    assign wr_sel = s_axi_awaddr[3:2];
    assign rd_sel = s_axi_araddr[3:2];

    // ready_q holds the slave off for the first cycle after reset release.
    assign aw_hs         = ready_q && (wr_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = aw_hs;
    assign s_axi_wready  = aw_hs;
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = ready_q && (rd_state_q == R_IDLE);
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign s_axi_rvalid  = (rd_state_q == R_VALID);
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rdata   = rdata_q;
    assign interrupt     = interrupt_q;

    assign ctrl_wr  = aw_hs && (wr_sel == REG_CTRL);
    assign stat_rd  = ar_hs && (rd_sel == REG_STAT);
    assign tx_push  = aw_hs && (wr_sel == REG_TX_FIFO);
    assign tx_flush = ctrl_wr && s_axi_wdata[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr && s_axi_wdata[CTRL_RX_FLUSH];
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_head;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_pop   = ar_hs && (rd_sel == REG_RX_FIFO) && !rx_empty;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (s_axi_aclk),
        .rst_ni  (s_axi_aresetn),
        .flush_i (tx_flush),
        .push_i  (tx_push),
        .data_i  (s_axi_wdata[7:0]),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (s_axi_aclk),
        .rst_ni  (s_axi_aresetn),
        .flush_i (rx_flush),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    always_comb begin
        stat                    = '0;
        stat[STAT_RX_NOT_EMPTY] = !rx_empty;
        stat[STAT_RX_FULL]      = rx_full;
        stat[STAT_TX_EMPTY]     = tx_empty;
        stat[STAT_TX_FULL]      = tx_full;
        stat[STAT_INTR_EN]      = intr_en_q;
        stat[STAT_OVERRUN]      = overrun_q;
        stat[STAT_FRAME_ERR]    = frame_err_q;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (aw_hs) wr_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_VALID;
            R_VALID: if (s_axi_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
        if (ar_hs) begin
            rdata_d = '0;
            if (rd_sel == REG_RX_FIFO && !rx_empty) begin
                rdata_d[7:0] = rx_head;
            end else if (rd_sel == REG_STAT) begin
                rdata_d[STAT_WIDTH-1:0] = stat;
            end
        end
    end

    // Sticky error flags: a new event in the same cycle as a STAT read wins.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        intr_en_d   = intr_en_q;
        if (stat_rd) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_valid && rx_full && !rx_pop) begin
            overrun_d = 1'b1;
        end
        if (rx_valid && rx_frame_err) begin
            frame_err_d = 1'b1;
        end
        if (ctrl_wr) begin
            intr_en_d = s_axi_wdata[CTRL_INTR_EN];
        end
        interrupt_d = intr_en_q && ((rx_was_empty_q && !rx_empty) ||
                                    (!tx_was_empty_q && tx_empty) ||
                                    (!intr_en_prev_q && (!rx_empty || tx_empty)));
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_state_q     <= W_IDLE;
            rd_state_q     <= R_IDLE;
            rdata_q        <= '0;
            ready_q        <= 1'b0;
            intr_en_q      <= 1'b0;
            overrun_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            rx_was_empty_q <= 1'b1;
            tx_was_empty_q <= 1'b1;
            intr_en_prev_q <= 1'b0;
            interrupt_q    <= 1'b0;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            rdata_q        <= rdata_d;
            ready_q        <= 1'b1;
            intr_en_q      <= intr_en_d;
            overrun_q      <= overrun_d;
            frame_err_q    <= frame_err_d;
            rx_was_empty_q <= rx_empty;
            tx_was_empty_q <= tx_empty;
            intr_en_prev_q <= intr_en_q;
            interrupt_q    <= interrupt_d;
        end
    end

endmodule

// File: tb/tb_uart_axil_regs.sv
// Self-checking bench for uart_axil_regs: register-map vector table plus
// scoreboarded TX/RX byte traffic and multi-cycle handshake corner cases.
module tb_uart_axil_regs;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [7:0]  txData, rxData;
    logic        txValid, txReady, rxValid, rxFrameErr, interrupt;

    int          checks = 0;
    int          errors = 0;
    int          intCount = 0;
    logic [7:0]  txQ[$];
    logic [7:0]  rxQ[$];

    typedef struct {
        bit          doWrite;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [31:0] raddr;
        logic [31:0] expected;
        string       name;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_axil_regs #(
        .S_AXI_ADDR_WIDTH(32),
        .S_AXI_DATA_WIDTH(32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .tx_data       (txData),
        .tx_valid      (txValid),
        .tx_ready      (txReady),
        .rx_data       (rxData),
        .rx_valid      (rxValid),
        .rx_frame_err  (rxFrameErr),
        .interrupt     (interrupt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // TX scoreboard and interrupt pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (interrupt) intCount++;
        if (aresetn && txValid && txReady) begin
            if (txQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got byte 0x%02h, expected none", txData);
            end else begin
                checkOutput("tx_data", {24'b0, txData}, {24'b0, txQ.pop_front()});
            end
        end
    end

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data);
        int n;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("aw_accept");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("bvalid");
        checkOutput("bresp", {30'b0, bresp}, 32'h0);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("ar_accept");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        #1;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("rvalid");
        data = rdata;
        checkOutput("rresp", {30'b0, rresp}, 32'h0);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic writeTx(input logic [7:0] b);
        if (txQ.size() < DEPTH) txQ.push_back(b);
        axiWrite(32'h4, {24'b0, b});
    endtask

    task automatic readRx();
        logic [31:0] d;
        logic [31:0] exp;
        axiRead(32'h0, d);
        exp = (rxQ.size() != 0) ? {24'b0, rxQ.pop_front()} : 32'h0;
        checkOutput("rx_read", d, exp);
    endtask

    task automatic readStat(input string name, input logic [31:0] exp);
        logic [31:0] d;
        axiRead(32'h8, d);
        checkOutput(name, d, exp);
    endtask

    task automatic strobeRx(input logic [7:0] b, input logic ferr);
        rxData     = b;
        rxValid    = 1'b1;
        rxFrameErr = ferr;
        if (rxQ.size() < DEPTH) rxQ.push_back(b);
        tick();
        rxValid    = 1'b0;
        rxFrameErr = 1'b0;
    endtask

    task automatic waitTxDrain();
        int n;
        n = 0;
        while ((txQ.size() != 0 || txValid) && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) timeoutFail("tx_drain");
    endtask

    task automatic applyStimulus();
        logic [31:0] d;
        int n;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].doWrite) axiWrite(vecs[i].waddr, vecs[i].wdat);
            axiRead(vecs[i].raddr, d);
            checkOutput(vecs[i].name, d, vecs[i].expected);
        end

        txReady = 1'b1;
        writeTx(8'h41);
        writeTx(8'h42);
        waitTxDrain();
        readStat("stat_tx_empty", 32'h04);

        txReady = 1'b0;
        for (int i = 0; i < 17; i++) writeTx(8'h60 + 8'(i));
        readStat("stat_tx_full", 32'h08);
        txReady = 1'b1;
        waitTxDrain();
        readStat("stat_tx_drained", 32'h04);

        for (int i = 0; i < 17; i++) strobeRx(8'(i), 1'b0);
        for (int i = 0; i < 16; i++) readRx();
        readStat("stat_overrun", 32'h24);
        readStat("stat_overrun_cleared", 32'h04);
        readRx();

        strobeRx(8'hA5, 1'b1);
        readStat("stat_frame_err", 32'h45);
        readRx();
        readStat("stat_frame_cleared", 32'h04);

        intCount = 0;
        axiWrite(32'hC, 32'h10);
        repeat (4) tick();
        checkOutput("intr_enable_rise", intCount, 1);
        intCount = 0;
        strobeRx(8'h77, 1'b0);
        repeat (4) tick();
        checkOutput("intr_rx_arrival", intCount, 1);
        readStat("stat_intr_en", 32'h15);
        axiWrite(32'hC, 32'h02);
        rxQ.delete();
        readStat("stat_rx_flushed", 32'h04);
        readRx();

        // Write response held off by bready while a second write waits.
        txQ.push_back(8'h33);
        awaddr  = 32'h4;
        wdata   = 32'h33;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("hold_aw_accept");
        tick();
        wdata = 32'h34;
        for (int i = 0; i < 5; i++) begin
            checkOutput("b_hold", {27'b0, awready, wready, bvalid, bresp}, 32'h04);
            tick();
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("b_released", {31'b0, bvalid}, 32'h0);
        waitTxDrain();

        // Read data held off by rready while a second read waits.
        araddr  = 32'h8;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("hold_ar_accept");
        tick();
        araddr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("r_hold", {28'b0, arready, rvalid, rresp}, 32'h04);
            checkOutput("r_hold_data", rdata, 32'h04);
            tick();
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput("r_released", {31'b0, rvalid}, 32'h0);

        // Reset while the write response is pending.
        awaddr  = 32'hC;
        wdata   = 32'h0;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 20) timeoutFail("rst_aw_accept");
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("bvalid_before_reset", {31'b0, bvalid}, 32'h1);
        aresetn = 1'b0;
        tick();
        checkOutput("bvalid_after_reset", {31'b0, bvalid}, 32'h0);
        aresetn = 1'b1;
        txQ.delete();
        rxQ.delete();
        tick();
        writeTx(8'h5A);
        waitTxDrain();
        readStat("stat_after_reset_write", 32'h04);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0,  32'h00, 32'h8,   32'h04, "stat_reset"};
        vecs[1] = '{1'b1, 32'h8,  32'hFF, 32'h8,   32'h04, "stat_write_ignored"};
        vecs[2] = '{1'b1, 32'h0,  32'h55, 32'h0,   32'h00, "rx_write_ignored"};
        vecs[3] = '{1'b0, 32'h0,  32'h00, 32'h4,   32'h00, "tx_fifo_read_zero"};
        vecs[4] = '{1'b0, 32'h0,  32'h00, 32'hC,   32'h00, "ctrl_read_zero"};
        vecs[5] = '{1'b1, 32'hC,  32'h00, 32'hF08, 32'h04, "stat_alias"};
        vecs[6] = '{1'b1, 32'h1C, 32'h10, 32'h8,   32'h14, "ctrl_alias_intr_en"};
        vecs[7] = '{1'b1, 32'hC,  32'h00, 32'h8,   32'h04, "ctrl_intr_off"};

        aresetn    = 1'b0;
        awaddr     = '0;
        wdata      = '0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        araddr     = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        txReady    = 1'b1;
        rxData     = '0;
        rxValid    = 1'b0;
        rxFrameErr = 1'b0;

        tick();
        tick();
        checkOutput("reset_outputs", {25'b0, awready, arready, bvalid, rvalid, txValid, interrupt, 1'b0}, 32'h0);
        checkOutput("reset_resp", {28'b0, bresp, rresp}, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        tick();
        checkOutput("arready_after_release", {31'b0, arready}, 32'h1);

        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
